// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline FSM encoding, instruction width and NOP word
package fetch_stage_pkg;
  typedef enum logic {S_REQ, S_HOLD} fetch_state_t;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = '0;
endpackage

// File: rtl/fetch_stage.sv
// fetch_stage: PC, imem request FSM with stall hold buffer, and IF/ID register
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump_taken,
  input  logic [31:0]        j_addr,
  input  logic               branch_taken,
  input  logic [31:0]        branch_addr,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid
);
  fetch_state_t state;
  logic [INSTR_W-1:0] hold_instr;
  logic [31:0] hold_pc4, pc4, target;
  logic redirect;
  assign redirect  = jump_taken | branch_taken;
  assign target    = jump_taken ? j_addr : branch_addr;
  assign pc4       = pc + 32'd4;
  assign imem_req  = state == S_REQ;
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      if_id_instr <= NOP;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      hold_instr  <= NOP;
      hold_pc4    <= '0;
    end else if (redirect) begin
      // redirect beats stall; any word returned this cycle is wrong-path
      state       <= S_REQ;
      pc          <= {target[31:2], 2'b00};
      if_id_valid <= 1'b0;
    end else if (state == S_REQ) begin
      if (imem_ready && !stall) begin
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc4;
        if_id_valid <= 1'b1;
        pc          <= pc4;
      end else if (imem_ready) begin
        hold_instr <= imem_rdata;
        hold_pc4   <= pc4;
        state      <= S_HOLD;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
      end
    end else if (!stall) begin
      if_id_instr <= hold_instr;
      if_id_pc4   <= hold_pc4;
      if_id_valid <= 1'b1;
      pc          <= pc4;
      state       <= S_REQ;
    end
  end
endmodule
